tempo_timer: RTL

- Multi-channel, parametrised pacing timer. Generalises the single 1/2/4/8/16 Hz flash timer.
- Each channel emits one-cycle pulses at BASE_HZ·2^level. Each channel is independently loadable and can run periodic or one-shot.
- Each channel supports halt (freeze) and a queued "speed-up" step applied at the next period boundary.
- Feeds the FSM and colour-flash logic: channel 0 paces colour flashes, channel 1 paces the player-response timeout.

---
 rtl/tempo_timer_if.sv | 24 ++
 rtl/tempo_timer.sv | 114 +++++++++++
 2 files changed

// File: rtl/tempo_timer_if.sv
// Control/status bundle for tempo_timer: per-channel load/mode/step/halt in, pulse/active/level out.
// Pure wiring; no latency and no backpressure.
interface tempo_timer_if #(
  parameter int CH = 2
);
  logic [CH-1:0]   load;
  logic [3*CH-1:0] speed;
  logic [CH-1:0]   oneshot;
  logic [CH-1:0]   step_up;
  logic [CH-1:0]   halt;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   active;
  logic [3*CH-1:0] level;

  modport master (
    output load, speed, oneshot, step_up, halt,
    input  pulse, active, level
  );

  modport slave (
    input  load, speed, oneshot, step_up, halt,
    output pulse, active, level
  );
endinterface

// File: rtl/tempo_timer.sv
// Multi-channel pacing timer: one-cycle pulse every PERIOD(level)+1 cycles, periodic or one-shot.
// Latency: first pulse P+1 edges after load, outputs registered; backpressure: none, halt freezes a channel.
module tempo_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BASE_HZ = 1,
  parameter int LEVELS  = 6,
  parameter int CH      = 2,
  parameter int W       = 26
) (
  input logic         clk,
  input logic         reset,
  tempo_timer_if.slave tif
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  localparam logic [2:0] MAX_LVL = 3'(LEVELS - 1);

  if (LEVELS < 1 || LEVELS > 8) begin : g_bad_levels
    $error("tempo_timer: LEVELS must be in 1..8");
  end
  if (longint'(CLK_HZ / BASE_HZ - 1) >= (longint'(1) << W)) begin : g_bad_width
    $error("tempo_timer: W too narrow for CLK_HZ/BASE_HZ-1");
  end
  if (CLK_HZ / (BASE_HZ << (LEVELS - 1)) - 1 < 0) begin : g_bad_period
    $error("tempo_timer: fastest level has a negative period");
  end

  // Reload values per level; entries beyond LEVELS are unreachable because level is clamped.
  logic [W-1:0] period_tab [8];
  for (genvar s = 0; s < 8; s++) begin : g_period
    if (s < LEVELS) begin : g_used
      assign period_tab[s] = W'(CLK_HZ / (BASE_HZ << s) - 1);
    end else begin : g_unused
      assign period_tab[s] = '0;
    end
  end

  function automatic logic [2:0] clamp_lvl(input logic [2:0] s);
    return ({1'b0, s} >= 4'(LEVELS)) ? MAX_LVL : s;
  endfunction

  function automatic logic [2:0] inc_lvl(input logic [2:0] l);
    return (l >= MAX_LVL) ? MAX_LVL : l + 3'd1;
  endfunction

  state_e               st_q [CH];
  state_e               st_d [CH];
  logic [CH-1:0][W-1:0] cnt_q, cnt_d;
  logic [CH-1:0][2:0]   lvl_q, lvl_d;
  logic [CH-1:0]        mode_q, mode_d;
  logic [CH-1:0]        pend_q, pend_d;
  logic [CH-1:0]        pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        st_q[c]  <= ST_IDLE;
        cnt_q[c] <= period_tab[0];
      end
      lvl_q   <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      pulse_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    pulse_d = '0;
    for (int c = 0; c < CH; c++) begin
      if (tif.load[c]) begin
        lvl_d[c]  = clamp_lvl(tif.speed[3*c +: 3]);
        cnt_d[c]  = period_tab[clamp_lvl(tif.speed[3*c +: 3])];
        mode_d[c] = tif.oneshot[c];
        st_d[c]   = ST_ACTIVE;
        pend_d[c] = 1'b0;
      end else if (st_q[c] == ST_ACTIVE && !tif.halt[c]) begin
        if (cnt_q[c] != '0) begin
          cnt_d[c]  = cnt_q[c] - W'(1);
          pend_d[c] = pend_q[c] | tif.step_up[c];
        end else begin
          pulse_d[c] = 1'b1;
          if (mode_q[c]) begin
            st_d[c] = ST_IDLE;
          end else begin
            // A step request arriving on the boundary itself counts toward the next one.
            lvl_d[c]  = pend_q[c] ? inc_lvl(lvl_q[c]) : lvl_q[c];
            cnt_d[c]  = period_tab[pend_q[c] ? inc_lvl(lvl_q[c]) : lvl_q[c]];
            pend_d[c] = tif.step_up[c];
          end
        end
      end
    end
  end

  assign tif.pulse = pulse_q;
  assign tif.level = lvl_q;
  for (genvar c = 0; c < CH; c++) begin : g_active
    assign tif.active[c] = (st_q[c] == ST_ACTIVE);
  end

endmodule
